commit_checker: RTL and testbench

COMMIT_CHECKER -- requirements
Module: commit_checker

---
 rtl/singlecycle_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/commit_checker.sv | 155 +++++++++++++++
 tb/tb_commit_checker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// Types shared by the commit checker: FSM states, error causes, and the
// packed expected-commit entry that is queued in the FIFO.
package singlecycle_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } check_state_e;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        MISMATCH  = 3'd1,
        UNDERFLOW = 3'd2,
        TIMEOUT   = 3'd3
    } err_code_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
        logic        rd_we;
    } commit_entry_t;

    localparam int ENTRY_W = $bits(commit_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a combinational head read.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/commit_checker.sv
// Lock-step commit checker: queues expected commits from a reference model
// and compares each DUT retirement against the FIFO head.
module commit_checker
    import singlecycle_pkg::*;
#(
    parameter int DEPTH            = 8,
    parameter int TIMEOUT_CYC      = 1024,
    parameter int STOP_ON_MISMATCH = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_drain,
    input  logic        i_exp_vld,
    output logic        o_exp_rdy,
    input  logic [31:0] i_exp_pc,
    input  logic [31:0] i_exp_rd_data,
    input  logic [4:0]  i_exp_rd_addr,
    input  logic        i_exp_rd_we,
    input  logic        i_act_vld,
    input  logic [31:0] i_act_pc,
    input  logic [31:0] i_act_rd_data,
    input  logic [4:0]  i_act_rd_addr,
    input  logic        i_act_rd_we,
    output logic [1:0]  o_state,
    output logic        o_mismatch,
    output logic [2:0]  o_err_code,
    output logic [31:0] o_err_act_pc,
    output logic [31:0] o_err_exp_pc,
    output logic [31:0] o_pass_cnt,
    output logic [31:0] o_fail_cnt
);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // rd_addr/rd_data only matter for a real register write (x0 is never written)
    function automatic logic entry_match(input commit_entry_t e, input commit_entry_t a);
        if (e.pc != a.pc || e.rd_we != a.rd_we) return 1'b0;
        if (e.rd_we && e.rd_addr != 5'd0)
            return (e.rd_addr == a.rd_addr) && (e.rd_data == a.rd_data);
        return 1'b1;
    endfunction

    check_state_e  state_q, state_d;
    err_code_e     err_q, err_d;
    logic [31:0]   err_act_q, err_act_d, err_exp_q, err_exp_d;
    logic [31:0]   pass_q, pass_d, fail_q, fail_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          vld_p1_q, match_p1_q;
    logic [31:0]   act_pc_p1_q, exp_pc_p1_q;

    commit_entry_t exp_in, act_in, head;
    logic          full, empty, run, push, pop, uflow, tmo_hit, mis_p1, fatal;

    assign exp_in = '{pc: i_exp_pc, rd_data: i_exp_rd_data, rd_addr: i_exp_rd_addr, rd_we: i_exp_rd_we};
    assign act_in = '{pc: i_act_pc, rd_data: i_act_rd_data, rd_addr: i_act_rd_addr, rd_we: i_act_rd_we};

    assign run       = (state_q == RUN);
    assign o_exp_rdy = i_rst_n && (state_q == IDLE || run) && !full;
    assign push      = i_exp_vld && o_exp_rdy;
    assign pop       = run && i_act_vld && !empty;
    assign uflow     = run && i_act_vld && empty;
    assign tmo_hit   = run && !i_act_vld && (tmo_q == TMO_LAST);
    assign mis_p1    = vld_p1_q && !match_p1_q;
    assign fatal     = (mis_p1 && STOP_ON_MISMATCH != 0) || uflow || tmo_hit;

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_exp_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (exp_in),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        err_act_d = err_act_q;
        err_exp_d = err_exp_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tmo_d     = (run && !i_act_vld) ? tmo_q + 32'd1 : 32'd0;

        unique case (state_q)
            IDLE:    if (i_en) state_d = RUN;
            RUN:     if (fatal) state_d = ERROR;
                     else if (i_drain && empty && !i_act_vld) state_d = DONE;
            default: state_d = state_q;
        endcase

        if (vld_p1_q) begin
            if (match_p1_q) pass_d = sat_inc(pass_q);
            else            fail_d = sat_inc(fail_q);
        end

        // An older registered mismatch outranks a same-cycle underflow/timeout
        if (err_q == NONE) begin
            if (mis_p1) begin
                err_d     = MISMATCH;
                err_act_d = act_pc_p1_q;
                err_exp_d = exp_pc_p1_q;
            end else if (uflow) begin
                err_d     = UNDERFLOW;
                err_act_d = i_act_pc;
                err_exp_d = 32'd0;
            end else if (tmo_hit) begin
                err_d     = TIMEOUT;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            err_q     <= NONE;
            err_act_q <= '0;
            err_exp_q <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            tmo_q     <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            err_act_q <= err_act_d;
            err_exp_q <= err_exp_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            tmo_q     <= tmo_d;
            vld_p1_q  <= pop;
        end
    end

    // p0 -> p1: compare result and PCs registered at the commit edge
    always_ff @(posedge i_clk) begin
        match_p1_q  <= entry_match(head, act_in);
        act_pc_p1_q <= i_act_pc;
        exp_pc_p1_q <= head.pc;
    end

    assign o_state      = state_q;
    assign o_mismatch   = mis_p1;
    assign o_err_code   = err_q;
    assign o_err_act_pc = err_act_q;
    assign o_err_exp_pc = err_exp_q;
    assign o_pass_cnt   = pass_q;
    assign o_fail_cnt   = fail_q;

endmodule

// File: tb/tb_commit_checker.sv
// Bench for commit_checker: queue-based reference model checked every cycle,
// directed scenarios for the called-out cases, then randomized commit streams.
module tb_commit_checker;
    import singlecycle_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;
    localparam int STOP  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, drain, exp_vld, exp_we, act_vld, act_we;
    logic [31:0] exp_pc, exp_data, act_pc, act_data;
    logic [4:0]  exp_addr, act_addr;
    logic        exp_rdy, mismatch;
    logic [1:0]  state;
    logic [2:0]  err_code;
    logic [31:0] err_act_pc, err_exp_pc, pass_cnt, fail_cnt;

    commit_checker #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .STOP_ON_MISMATCH(STOP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_drain(drain),
        .i_exp_vld(exp_vld), .o_exp_rdy(exp_rdy), .i_exp_pc(exp_pc),
        .i_exp_rd_data(exp_data), .i_exp_rd_addr(exp_addr), .i_exp_rd_we(exp_we),
        .i_act_vld(act_vld), .i_act_pc(act_pc), .i_act_rd_data(act_data),
        .i_act_rd_addr(act_addr), .i_act_rd_we(act_we),
        .o_state(state), .o_mismatch(mismatch), .o_err_code(err_code),
        .o_err_act_pc(err_act_pc), .o_err_exp_pc(err_exp_pc),
        .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
    } ent_t;

    ent_t         mq[$];
    check_state_e m_state = IDLE;
    err_code_e    m_err = NONE;
    logic [31:0]  m_eact = 0, m_eexp = 0, m_pass = 0, m_fail = 0;
    int           m_idle = 0;
    logic         p_vld = 0, p_match = 0;
    logic [31:0]  p_apc = 0, p_epc = 0;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    function automatic logic commit_ok(input ent_t e);
        if (e.pc != act_pc || e.we != act_we) return 1'b0;
        if (!e.we || e.addr == 0) return 1'b1;
        return (e.addr == act_addr) && (e.data == act_data);
    endfunction

    task automatic note_err(input err_code_e c, input logic [31:0] a, input logic [31:0] e);
        if (m_err == NONE) begin
            m_err = c; m_eact = a; m_eexp = e;
        end
    endtask

    function automatic logic m_rdy();
        return rst_n && (m_state == IDLE || m_state == RUN) && (mq.size() < DEPTH);
    endfunction

    // Applies the spec rules to the inputs present before the coming edge
    task automatic model_edge();
        logic push, in_run, committed, was_empty, fatal, n_vld, n_match;
        logic [31:0] n_apc, n_epc;
        ent_t e, ne;
        if (!rst_n) begin
            mq.delete();
            m_state = IDLE; m_err = NONE; m_eact = 0; m_eexp = 0;
            m_pass = 0; m_fail = 0; m_idle = 0; p_vld = 0;
            return;
        end
        push      = exp_vld && m_rdy();
        in_run    = (m_state == RUN);
        committed = in_run && act_vld;
        was_empty = (mq.size() == 0);
        fatal     = 0;
        n_vld = 0; n_match = 0; n_apc = 0; n_epc = 0;
        if (committed && !was_empty) begin
            e = mq.pop_front();
            n_vld = 1; n_match = commit_ok(e); n_apc = act_pc; n_epc = e.pc;
        end
        if (p_vld) begin
            if (p_match) m_pass = sat(m_pass);
            else begin
                m_fail = sat(m_fail);
                note_err(MISMATCH, p_apc, p_epc);
                if (STOP != 0) fatal = 1;
            end
        end
        if (committed && was_empty) begin
            note_err(UNDERFLOW, act_pc, 32'd0);
            fatal = 1;
        end
        if (in_run && !act_vld) begin
            m_idle++;
            if (m_idle >= TMO) begin
                note_err(TIMEOUT, 32'd0, 32'd0);
                fatal = 1;
            end
        end else m_idle = 0;
        if (m_state == IDLE && en) m_state = RUN;
        else if (in_run) begin
            if (fatal) m_state = ERROR;
            else if (drain && was_empty && !act_vld) m_state = DONE;
        end
        if (push) begin
            ne.pc = exp_pc; ne.data = exp_data; ne.addr = exp_addr; ne.we = exp_we;
            mq.push_back(ne);
        end
        p_vld = n_vld; p_match = n_match; p_apc = n_apc; p_epc = n_epc;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("state", 32'(state), 32'(m_state));
        check("mismatch", 32'(mismatch), 32'(p_vld && !p_match));
        check("err_code", 32'(err_code), 32'(m_err));
        check("err_act_pc", err_act_pc, m_eact);
        check("err_exp_pc", err_exp_pc, m_eexp);
        check("pass_cnt", pass_cnt, m_pass);
        check("fail_cnt", fail_cnt, m_fail);
        check("exp_rdy", 32'(exp_rdy), 32'(m_rdy()));
    endtask

    task automatic idle_in();
        en = 0; drain = 0; exp_vld = 0; act_vld = 0;
        exp_pc = 0; exp_data = 0; exp_addr = 0; exp_we = 0;
        act_pc = 0; act_data = 0; act_addr = 0; act_we = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic set_exp(input logic [31:0] pc, input logic [31:0] d, input logic [4:0] a, input logic w);
        exp_vld = 1; exp_pc = pc; exp_data = d; exp_addr = a; exp_we = w;
    endtask

    task automatic set_act(input logic [31:0] pc, input logic [31:0] d, input logic [4:0] a, input logic w);
        act_vld = 1; act_pc = pc; act_data = d; act_addr = a; act_we = w;
    endtask

    task automatic start_run();
        en = 1; step(); en = 0;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        step();
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_rdy", 32'(exp_rdy), 32'd0);
        check("rst_err", 32'(err_code), 32'(NONE));
        rst_n = 1;

        // three matching commits then drain; a commit in IDLE is ignored
        do_reset();
        set_act(32'h0, 32'h0, 5'd0, 1'b0); step(); act_vld = 0;
        check("idle_commit_ignored", pass_cnt + fail_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_exp(32'(i * 4), 32'h100 + 32'(i), 5'(i + 1), 1'b1); step();
        end
        exp_vld = 0;
        start_run();
        for (int i = 0; i < 3; i++) begin
            set_act(32'(i * 4), 32'h100 + 32'(i), 5'(i + 1), 1'b1); step();
        end
        act_vld = 0; drain = 1;
        repeat (3) step();
        check("seq_state", 32'(state), 32'(DONE));
        check("seq_pass", pass_cnt, 32'd3);
        check("seq_fail", fail_cnt, 32'd0);

        // data mismatch on x3
        do_reset();
        set_exp(32'h40, 32'h5, 5'd3, 1'b1); step(); exp_vld = 0;
        start_run();
        set_act(32'h40, 32'h6, 5'd3, 1'b1);
        check("mis_before", 32'(mismatch), 32'd0);
        step(); act_vld = 0;
        check("mis_pulse", 32'(mismatch), 32'd1);
        step();
        check("mis_pulse_end", 32'(mismatch), 32'd0);
        check("mis_state", 32'(state), 32'(ERROR));
        check("mis_code", 32'(err_code), 32'(MISMATCH));
        check("mis_act_pc", err_act_pc, 32'h40);
        check("mis_exp_pc", err_exp_pc, 32'h40);
        step();
        check("mis_no_repeat", 32'(mismatch), 32'd0);

        // x0 destination and we=0 ignore data/addr
        do_reset();
        set_exp(32'h80, 32'h11, 5'd0, 1'b1); step();
        set_exp(32'h84, 32'h1, 5'd7, 1'b0); step(); exp_vld = 0;
        start_run();
        set_act(32'h80, 32'h22, 5'd0, 1'b1); step();
        set_act(32'h84, 32'h2, 5'd9, 1'b0); step(); act_vld = 0;
        step();
        check("x0_pass", pass_cnt, 32'd2);
        check("x0_fail", fail_cnt, 32'd0);

        // commit into empty FIFO while a push arrives
        do_reset();
        start_run();
        set_exp(32'h200, 32'h1, 5'd1, 1'b1);
        set_act(32'h300, 32'h1, 5'd1, 1'b1);
        step(); idle_in();
        check("uf_state", 32'(state), 32'(ERROR));
        check("uf_code", 32'(err_code), 32'(UNDERFLOW));
        check("uf_exp_pc", err_exp_pc, 32'd0);
        check("uf_act_pc", err_act_pc, 32'h300);
        check("uf_not_counted", pass_cnt + fail_cnt, 32'd0);

        // full FIFO, push+commit together, order across pointer wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_exp(32'h1000 + 32'(i * 4), 32'(i), 5'd2, 1'b1); step();
        end
        exp_vld = 0;
        check("full_rdy", 32'(exp_rdy), 32'd0);
        start_run();
        set_exp(32'h1020, 32'd8, 5'd2, 1'b1);
        set_act(32'h1000, 32'd0, 5'd2, 1'b1);
        check("full_rdy_commit", 32'(exp_rdy), 32'd0);
        step(); act_vld = 0;
        check("after_pop_rdy", 32'(exp_rdy), 32'd1);
        step(); exp_vld = 0;
        check("refill_rdy", 32'(exp_rdy), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            set_act(32'h1000 + 32'(i * 4), 32'(i), 5'd2, 1'b1); step();
        end
        act_vld = 0; drain = 1;
        repeat (2) step();
        check("wrap_pass", pass_cnt, 32'd9);
        check("wrap_fail", fail_cnt, 32'd0);
        check("wrap_state", 32'(state), 32'(DONE));

        // timeout after TMO idle RUN cycles
        do_reset();
        start_run();
        repeat (TMO - 1) step();
        check("tmo_pre_state", 32'(state), 32'(RUN));
        step();
        check("tmo_state", 32'(state), 32'(ERROR));
        check("tmo_code", 32'(err_code), 32'(TIMEOUT));

        // reset mid-RUN: same-edge commit discarded, then pending compare discarded
        do_reset();
        set_exp(32'h500, 32'h1, 5'd4, 1'b1); step();
        set_exp(32'h504, 32'h1, 5'd4, 1'b1); step(); exp_vld = 0;
        start_run();
        set_act(32'h500, 32'h2, 5'd4, 1'b1); rst_n = 0;
        step(); idle_in();
        check("rst_mid_mis", 32'(mismatch), 32'd0);
        check("rst_mid_state", 32'(state), 32'(IDLE));
        rst_n = 1;
        set_exp(32'h600, 32'h1, 5'd4, 1'b1); step(); exp_vld = 0;
        start_run();
        set_act(32'h600, 32'h2, 5'd4, 1'b1); step(); act_vld = 0;
        rst_n = 0; step(); rst_n = 1;
        check("rst_pend_mis", 32'(mismatch), 32'd0);
        check("rst_pend_fail", fail_cnt, 32'd0);
        step();
        check("rst_pend_err", 32'(err_code), 32'(NONE));

        // randomized streams
        for (int s = 0; s < 8; s++) begin
            do_reset();
            for (int c = 0; c < 90; c++) begin
                idle_in();
                en = (c == 4);
                drain = (c >= 65);
                if (c < 65 && $urandom_range(0, 1) == 1) begin
                    set_exp($urandom, $urandom,
                            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            1'($urandom_range(0, 1)));
                end
                if (m_state == RUN) begin
                    if (mq.size() > 0 && $urandom_range(0, 9) < 6) begin
                        set_act(mq[0].pc, mq[0].data, mq[0].addr, mq[0].we);
                        if ($urandom_range(0, 24) == 0) begin
                            case ($urandom_range(0, 3))
                                0: act_pc   = act_pc ^ 32'h4;
                                1: act_data = act_data ^ 32'h1;
                                2: act_addr = act_addr ^ 5'h1;
                                default: act_we = ~act_we;
                            endcase
                        end
                    end else if (mq.size() == 0 && $urandom_range(0, 59) == 0) begin
                        set_act($urandom, $urandom, 5'd1, 1'b1);
                    end
                end
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
